mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- MEM stage access controller, directly downstream of the EX/MEM pipeline register.
- Turns the registered MemRead/MemWrite, address, store data, byte_select and LoadExtOp into a request/acknowledge transaction on the data-memory port.
- Aligns and extends load data for writeback, and produces mem_stall, which holds every pipeline register's we low until the access completes.
- Detects misaligned accesses and acknowledge timeouts.

Parameters:
- ACK_TIMEOUT, 255: maximum cycles in REQ waiting for dmem_ack before the access is aborted with mem_fault; legal range 1..65535.
- CNT_W, 16: width of the wait counter; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- execution_result  in  32  effective address from EX/MEM (bit 0 = MSB; bits 30:31 = byte offset)
- busB  in  32  store data from EX/MEM
- MemRead  in  1  load request from EX/MEM
- MemWrite  in  1  store request from EX/MEM
- byte_select  in  2  access size: 00 byte, 01 halfword, 10/11 word
- LoadExtOp  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write, valid while dmem_req=1
- dmem_addr  out  30  word address = execution_result[0:29]
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte-lane enables; wstrb[0] covers bits 0:7
- dmem_ack  in  1  single-cycle completion pulse from memory
- dmem_rdata  in  32  read word, valid when dmem_ack=1
- load_data  out  32  aligned/extended load result to MEM/WB
- mem_stall  out  1  1 = hold all upstream pipeline registers (we=0)
- mem_misalign  out  1  one-cycle pulse: misaligned access suppressed
- mem_fault  out  1  one-cycle pulse: ack timeout

Behaviour:
- Access present: acc = MemRead | MemWrite. If both are set, the access is treated as a write.
- Misalignment: halfword with offset[1]=1, or word with offset != 00.
- Misaligned access: no dmem_req is issued. mem_misalign pulses in that same cycle, mem_stall stays 0, and load_data = 0.
- FSM states:
  - IDLE: if acc and aligned, go to REQ; mem_stall=1 combinationally in this cycle. Otherwise stay in IDLE with mem_stall=0.
  - REQ: dmem_req=1, counter increments each cycle. If dmem_ack, capture the extracted data into load_data and go to DONE. Else if counter == ACK_TIMEOUT, set load_data=0, pulse mem_fault, go to DONE. mem_stall=1.
  - DONE: mem_stall=0 so the pipeline advances at this edge; load_data is held valid; unconditionally return to IDLE. A new access seen in the following IDLE cycle starts a fresh transaction.
- dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are registered. They are loaded on the IDLE->REQ edge and stay stable throughout REQ.
- dmem_req drops on the edge leaving REQ. An ack arriving in IDLE or DONE is ignored.
- Latency: an aligned access with ack in its first REQ cycle takes 3 cycles: IDLE, REQ, DONE.
- Store lanes:
  - byte: wdata = {4{busB[24:31]}}; wstrb = one-hot of offset (00 -> 1000, 11 -> 0001).
  - halfword: wdata = {2{busB[16:31]}}; wstrb = 1100 (offset 00) or 0011 (offset 10).
  - word: wdata = busB; wstrb = 1111.
- Loads: dmem_wstrb = 0000.
- Load extraction (big-endian):
  - byte at offset k uses rdata[8k:8k+7].
  - halfword at offset 0 uses rdata[0:15]; at offset 2 uses rdata[16:31].
  - Result is right-justified in load_data[24:31] or [16:31], with upper bits sign- or zero-extended per LoadExtOp.
- load_data for a store: unchanged from its previous value.
- Reset (asynchronous, any state): FSM to IDLE; dmem_req, dmem_we, dmem_wstrb, mem_misalign, mem_fault = 0; dmem_addr, dmem_wdata, load_data = 0; counter = 0. Reset during REQ abandons the transaction with no fault pulse.
- Counter: cleared on entry to REQ. Does not wrap, because the timeout fires first.

Test Plan:
- Word load at 0x00000100, ack after 2 REQ cycles, rdata=0xDEADBEEF -> dmem_addr=0x40, req held 2 cycles, mem_stall=1 for 3 cycles, load_data=0xDEADBEEF in DONE.
- Byte load at offset 3, rdata=0x112233F0: LoadExtOp=1 -> load_data=0xFFFFFFF0; LoadExtOp=0 -> 0x000000F0.
- Halfword store of busB=0x0000ABCD at address 0x...2 -> dmem_we=1, wstrb=0011, wdata=0xABCDABCD.
- Word load at address 0x...1 -> mem_misalign pulses, dmem_req stays 0, mem_stall=0, load_data=0.
- ACK_TIMEOUT=4, no ack -> dmem_req high 5 cycles, mem_fault pulses once, then DONE then IDLE.
- rst asserted mid-REQ -> dmem_req=0 immediately (asynchronous), FSM IDLE, no mem_fault; next access proceeds normally.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory access controller: request/ack handshake, store lane steering,
// big-endian load extraction, pipeline stall, misalignment and ack-timeout detection.
module mem_stage_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] execution_result,
    input  logic [31:0] busB,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  byte_select,
    input  logic        LoadExtOp,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        mem_fault
);

    // Vectors are [31:0]; big-endian bit k of the interface is SV bit 31-k.
    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e state_q, state_d;

    logic             req_q, we_q, ext_q;
    logic [29:0]      addr_q;
    logic [31:0]      wdata_q, load_q;
    logic [3:0]       wstrb_q;
    logic [1:0]       size_q, off_q;
    logic [CNT_W-1:0] cnt_q;

    logic        acc, misaligned, start, timeout;
    logic [1:0]  off;
    logic [31:0] wdata_nx, rd_ext;
    logic [3:0]  wstrb_nx;
    logic [7:0]  ext_byte;
    logic [15:0] ext_half;

    assign acc     = MemRead | MemWrite;
    assign off     = execution_result[1:0];
    assign start   = acc & ~misaligned;
    assign timeout = (cnt_q == CNT_W'(ACK_TIMEOUT));

    always_comb begin
        misaligned = 1'b0;
        case (byte_select)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    end

    // Store lane steering; MemWrite wins when both requests are set.
    always_comb begin
        wdata_nx = busB;
        wstrb_nx = 4'b0000;
        case (byte_select)
            2'b00: begin
                wdata_nx = {4{busB[7:0]}};
                wstrb_nx = 4'b1000 >> off;
            end
            2'b01: begin
                wdata_nx = {2{busB[15:0]}};
                wstrb_nx = off[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                wdata_nx = busB;
                wstrb_nx = 4'b1111;
            end
        endcase
        if (!MemWrite) begin
            wstrb_nx = 4'b0000;
        end
    end

    always_comb begin
        ext_byte = 8'h00;
        case (off_q)
            2'd0:    ext_byte = dmem_rdata[31:24];
            2'd1:    ext_byte = dmem_rdata[23:16];
            2'd2:    ext_byte = dmem_rdata[15:8];
            default: ext_byte = dmem_rdata[7:0];
        endcase
        ext_half = off_q[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
        case (size_q)
            2'b00:   rd_ext = {{24{ext_q & ext_byte[7]}}, ext_byte};
            2'b01:   rd_ext = {{16{ext_q & ext_half[15]}}, ext_half};
            default: rd_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StReq;
            StReq:  if (dmem_ack || timeout) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_stall    = 1'b0;
        mem_misalign = 1'b0;
        mem_fault    = 1'b0;
        unique case (state_q)
            StIdle: begin
                mem_stall    = start & ~rst;
                mem_misalign = acc & misaligned & ~rst;
            end
            StReq: begin
                mem_stall = 1'b1;
                mem_fault = ~dmem_ack & timeout;
            end
            default: ;
        endcase
    end

    // Port registers load on IDLE->REQ and hold through REQ; access shape is captured
    // so extraction does not depend on the stalled EX/MEM inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            ext_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            size_q  <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            load_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        req_q   <= 1'b1;
                        we_q    <= MemWrite;
                        addr_q  <= execution_result[31:2];
                        wdata_q <= wdata_nx;
                        wstrb_q <= wstrb_nx;
                        size_q  <= byte_select;
                        off_q   <= off;
                        ext_q   <= LoadExtOp;
                        cnt_q   <= '0;
                    end else if (acc && misaligned) begin
                        load_q <= '0;
                    end
                end
                StReq: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (dmem_ack) begin
                        req_q <= 1'b0;
                        if (!we_q) begin
                            load_q <= rd_ext;
                        end
                    end else if (timeout) begin
                        req_q  <= 1'b0;
                        load_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;
    // A suppressed misaligned access reads as zero in its own cycle.
    assign load_data  = mem_misalign ? 32'h0 : load_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: expected transactions queued at issue, checked when
// the request appears on the memory port and again when the access completes.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] execution_result, busB, dmem_rdata, dmem_wdata, load_data;
    logic        MemRead, MemWrite, LoadExtOp, dmem_ack;
    logic [1:0]  byte_select;
    logic        dmem_req, dmem_we, mem_stall, mem_misalign, mem_fault;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_wstrb;

    mem_stage_ctrl #(
        .ACK_TIMEOUT(4),
        .CNT_W      (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .execution_result(execution_result),
        .busB            (busB),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .byte_select     (byte_select),
        .LoadExtOp       (LoadExtOp),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_wstrb      (dmem_wstrb),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .load_data       (load_data),
        .mem_stall       (mem_stall),
        .mem_misalign    (mem_misalign),
        .mem_fault       (mem_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        bit          chk_wdata;
        logic [31:0] load;
        int          n_req;
        int          n_fault;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [29:0] a, input logic we, input logic [3:0] s,
                                input logic [31:0] wd, input bit cw, input logic [31:0] ld,
                                input int nr, input int nf);
        exp_t e;
        e.addr = a; e.we = we; e.wstrb = s; e.wdata = wd; e.chk_wdata = cw;
        e.load = ld; e.n_req = nr; e.n_fault = nf;
        return e;
    endfunction

    // ack_at: REQ cycle (1-based) in which dmem_ack is pulsed; 0 means never.
    task automatic access(input string tag, input logic [31:0] addr, input logic [31:0] bus,
                          input logic rd, input logic wr, input logic [1:0] bsel,
                          input logic ext, input int ack_at, input logic [31:0] rdata,
                          input exp_t e);
        exp_t cur;
        int   reqc, stallc, faultc;
        bit   done;
        cur = e; reqc = 0; faultc = 0; done = 1'b0;
        @(negedge clk);
        execution_result = addr; busB = bus; MemRead = rd; MemWrite = wr;
        byte_select = bsel; LoadExtOp = ext;
        sb.push_back(e);
        #1;
        stallc = int'(mem_stall);
        chk({tag, ".idle_misalign"}, 32'(mem_misalign), 32'd0);
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            #1;
            if (dmem_req) begin
                reqc++;
                if (reqc == 1 && sb.size() > 0) cur = sb.pop_front();
                stallc += int'(mem_stall);
                chk({tag, ".addr"}, 32'(dmem_addr), 32'(cur.addr));
                chk({tag, ".we"}, 32'(dmem_we), 32'(cur.we));
                chk({tag, ".wstrb"}, 32'(dmem_wstrb), 32'(cur.wstrb));
                if (cur.chk_wdata) chk({tag, ".wdata"}, dmem_wdata, cur.wdata);
                if (reqc == ack_at) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rdata;
                end
                #1;
                faultc += int'(mem_fault);
            end else begin
                done = 1'b1;
                dmem_ack = 1'b0;
                dmem_rdata = 32'h5A5A_5A5A;
                chk({tag, ".done_stall"}, 32'(mem_stall), 32'd0);
                chk({tag, ".done_load"}, load_data, cur.load);
                chk({tag, ".done_fault"}, 32'(mem_fault), 32'd0);
                MemRead = 1'b0; MemWrite = 1'b0;
            end
        end
        chk({tag, ".completed"}, 32'(done), 32'd1);
        chk({tag, ".req_cycles"}, 32'(reqc), 32'(cur.n_req));
        chk({tag, ".stall_cycles"}, 32'(stallc), 32'(cur.n_req + 1));
        chk({tag, ".fault_pulses"}, 32'(faultc), 32'(cur.n_fault));
        @(negedge clk);
        #1;
        chk({tag, ".held_load"}, load_data, cur.load);
        chk({tag, ".idle_req"}, 32'(dmem_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        execution_result = '0; busB = '0; MemRead = 1'b0; MemWrite = 1'b0;
        byte_select = 2'b00; LoadExtOp = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset.req", 32'(dmem_req), 32'd0);
        chk("reset.we", 32'(dmem_we), 32'd0);
        chk("reset.wstrb", 32'(dmem_wstrb), 32'd0);
        chk("reset.addr", 32'(dmem_addr), 32'd0);
        chk("reset.wdata", dmem_wdata, 32'd0);
        chk("reset.load", load_data, 32'd0);
        chk("reset.stall", 32'(mem_stall), 32'd0);
        chk("reset.fault", 32'(mem_fault), 32'd0);
        chk("reset.misalign", 32'(mem_misalign), 32'd0);
        rst = 1'b0;

        access("lw_ack2", 32'h0000_0100, 32'h0, 1, 0, 2'b10, 0, 2, 32'hDEAD_BEEF,
               mk(30'h40, 0, 4'b0000, 32'h0, 0, 32'hDEAD_BEEF, 2, 0));
        access("lb_sext", 32'h0000_0403, 32'h0, 1, 0, 2'b00, 1, 1, 32'h1122_33F0,
               mk(30'h100, 0, 4'b0000, 32'h0, 0, 32'hFFFF_FFF0, 1, 0));
        access("lb_zext", 32'h0000_0403, 32'h0, 1, 0, 2'b00, 0, 1, 32'h1122_33F0,
               mk(30'h100, 0, 4'b0000, 32'h0, 0, 32'h0000_00F0, 1, 0));
        access("sh_off2", 32'h0000_0802, 32'h0000_ABCD, 0, 1, 2'b01, 0, 1, 32'h0,
               mk(30'h200, 1, 4'b0011, 32'hABCD_ABCD, 1, 32'h0000_00F0, 1, 0));
        access("sb_off1", 32'h0000_0C01, 32'h1234_5678, 0, 1, 2'b00, 0, 3, 32'h0,
               mk(30'h300, 1, 4'b0100, 32'h7878_7878, 1, 32'h0000_00F0, 3, 0));
        access("lh_off0", 32'h0000_1000, 32'h0, 1, 0, 2'b01, 1, 1, 32'h8001_1234,
               mk(30'h400, 0, 4'b0000, 32'h0, 0, 32'hFFFF_8001, 1, 0));
        access("rw_word", 32'h0000_1004, 32'hCAFE_F00D, 1, 1, 2'b11, 0, 1, 32'h0,
               mk(30'h401, 1, 4'b1111, 32'hCAFE_F00D, 1, 32'hFFFF_8001, 1, 0));

        // Misaligned word load: suppressed, no stall, load_data reads zero.
        @(negedge clk);
        execution_result = 32'h0000_0101; MemRead = 1'b1; byte_select = 2'b10;
        #1;
        chk("mis_w.pulse", 32'(mem_misalign), 32'd1);
        chk("mis_w.stall", 32'(mem_stall), 32'd0);
        chk("mis_w.load", load_data, 32'd0);
        @(negedge clk);
        MemRead = 1'b0;
        #1;
        chk("mis_w.req", 32'(dmem_req), 32'd0);
        chk("mis_w.pulse_end", 32'(mem_misalign), 32'd0);
        chk("mis_w.load_after", load_data, 32'd0);
        execution_result = 32'h0000_0103; MemRead = 1'b1; byte_select = 2'b01;
        #1;
        chk("mis_h.pulse", 32'(mem_misalign), 32'd1);
        chk("mis_h.stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        MemRead = 1'b0;
        #1;
        chk("mis_h.req", 32'(dmem_req), 32'd0);

        access("lh_off2", 32'h0000_1402, 32'h0, 1, 0, 2'b01, 0, 1, 32'h1234_9876,
               mk(30'h500, 0, 4'b0000, 32'h0, 0, 32'h0000_9876, 1, 0));
        access("timeout", 32'h0000_2000, 32'h0, 1, 0, 2'b10, 0, 0, 32'h0,
               mk(30'h800, 0, 4'b0000, 32'h0, 0, 32'h0, 5, 1));
        access("lw_pre_rst", 32'h0000_0020, 32'h0, 1, 0, 2'b10, 0, 1, 32'h7777_1111,
               mk(30'h8, 0, 4'b0000, 32'h0, 0, 32'h7777_1111, 1, 0));

        // Asynchronous reset in the middle of REQ.
        @(negedge clk);
        execution_result = 32'h0000_0200; MemRead = 1'b1; byte_select = 2'b10;
        @(negedge clk);
        #1;
        chk("rst_mid.req_before", 32'(dmem_req), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid.req", 32'(dmem_req), 32'd0);
        chk("rst_mid.fault", 32'(mem_fault), 32'd0);
        chk("rst_mid.load", load_data, 32'd0);
        chk("rst_mid.addr", 32'(dmem_addr), 32'd0);
        MemRead = 1'b0;
        #1;
        chk("rst_mid.stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        access("lw_post_rst", 32'h0000_0010, 32'h0, 1, 0, 2'b10, 0, 1, 32'h0BAD_F00D,
               mk(30'h4, 0, 4'b0000, 32'h0, 0, 32'h0BAD_F00D, 1, 0));

        // Ack with no access outstanding must be ignored.
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
        @(negedge clk);
        #1;
        chk("stray_ack.req", 32'(dmem_req), 32'd0);
        chk("stray_ack.stall", 32'(mem_stall), 32'd0);
        chk("stray_ack.load", load_data, 32'h0BAD_F00D);
        dmem_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
